fetch_stage: RTL and testbench

- Instruction fetch stage: owns the PC register, issues requests to instruction memory, buffers returned words, and drives the IF/ID pipeline register.
- Sits directly upstream of the hazard detection unit and consumes its stall outputs.
- Exports IF/ID rs1/rs2 fields for load-use detection.
- Accepts branch/jump redirects from later stages and flushes wrong-path instructions.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/fetch_stage.sv | 218 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC, instruction
// field positions, the NOP encoding and the fetch buffer entry layout.
package cpu_pkg;

   localparam int unsigned ADDR_W           = 32;
   localparam int unsigned INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Register-source field positions inside an instruction word
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS2_LSB = 20;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

   // One buffered fetch: the word and the PC it was fetched from
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory.
//   master (fetch side) : drives imem_req_valid/imem_req_addr,
//                         samples imem_req_ready/imem_rsp_valid/imem_rsp_data
//   slave  (memory side): the mirror image
interface fetch_stage_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 32
) ();

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with push, pop, flush and an occupancy count.
// Ports:
//   clk, arst      clock, asynchronous active-high reset
//   i_push/i_data  write one entry (ignored during flush)
//   i_pop          drop the head entry (ignored when empty or during flush)
//   i_flush        empty the FIFO this edge
//   o_data         current head entry (undefined when o_count == 0)
//   o_count        number of valid entries
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   assign w_do_push = i_push && !i_flush;
   assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

   // Pointers and occupancy
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   // Storage holds data only; no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Callers throttle so that a push always finds a free slot
   a_no_push_when_full: assert property (@(posedge clk) disable iff (arst)
      !(w_do_push && (r_count == FULL_CNT)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order requests to
// instruction memory, buffers returned words and drives the IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating performance counters.
// Ports:
//   clk, arst                 clock, asynchronous active-high reset
//   stall_pc                  hold PC and issue no new request
//   stall_if_id               hold the IF/ID register and buffer head
//   redirect_valid/_pc        taken branch/jump: flush and refetch from _pc
//   imem (master)             instruction-memory request/response bundle
//   if_id_valid/_pc/_instr    IF/ID register contents (valid=0 is a bubble)
//   if_id_rs1/_rs2            register-source fields of if_id_instr
//   perf_*_cnt                bubble/stall/flush counters (FETCH_PERF_CNT_EN)
module fetch_stage #(
   parameter int unsigned       ADDR_W    = cpu_pkg::ADDR_W,
   parameter int unsigned       INSTR_W   = cpu_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(cpu_pkg::RESET_PC_DEFAULT),
   parameter int unsigned       BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               stall_pc,
   input  logic               stall_if_id,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   fetch_stage_if.master      imem,
   output logic               if_id_valid,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [4:0]         if_id_rs1,
   output logic [4:0]         if_id_rs2
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_bubble_cnt,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);

   localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
   localparam int unsigned E_ADDR_W  = cpu_pkg::ADDR_W;
   localparam int unsigned E_INSTR_W = cpu_pkg::INSTR_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   logic [ADDR_W-1:0]  r_pc;
   logic [CNT_W-1:0]   r_outstanding;
   logic [CNT_W-1:0]   r_drop_cnt;
   logic               r_if_id_valid;
   logic [ADDR_W-1:0]  r_if_id_pc;
   logic [INSTR_W-1:0] r_if_id_instr;

   logic [CNT_W-1:0]   w_buf_count;
   logic [CNT_W-1:0]   w_tag_count;
   logic [CNT_W-1:0]   w_inflight;
   logic [CNT_W-1:0]   w_out_next;
   logic [ADDR_W-1:0]  w_rsp_tag;
   cpu_pkg::fetch_entry_t w_push_entry;
   cpu_pkg::fetch_entry_t w_head_entry;
   logic w_req_valid;
   logic w_accept;
   logic w_rsp_drop;
   logic w_rsp_keep;
   logic w_tag_pop;
   logic w_buf_push;
   logic w_buf_pop;
   logic w_load_head;
   logic w_load_rsp;
   logic w_bubble;

   // Request throttle: every outstanding request owns a future buffer slot
   assign w_inflight  = w_buf_count + r_outstanding;
   assign w_req_valid = !arst && !redirect_valid && !stall_pc && (w_inflight < DEPTH_C);
   assign w_accept    = w_req_valid && imem.imem_req_ready;

   // Responses owed to a flushed path are discarded without touching the tags
   assign w_rsp_drop = imem.imem_rsp_valid && (r_drop_cnt != '0);
   assign w_tag_pop  = imem.imem_rsp_valid && (r_drop_cnt == '0);
   assign w_rsp_keep = w_tag_pop && !redirect_valid;

   assign imem.imem_req_valid = w_req_valid;
   assign imem.imem_req_addr  = r_pc;

   always_comb begin
      w_push_entry       = '0;
      w_push_entry.pc    = E_ADDR_W'(w_rsp_tag);
      w_push_entry.instr = E_INSTR_W'(imem.imem_rsp_data);
   end

   // IF/ID load selection: redirect > stall > buffer head > bypass > bubble
   always_comb begin
      w_load_head = 1'b0;
      w_load_rsp  = 1'b0;
      w_bubble    = 1'b0;
      w_buf_push  = 1'b0;
      w_buf_pop   = 1'b0;
      if (redirect_valid) begin
         w_buf_push = 1'b0;
      end else if (stall_if_id) begin
         w_buf_push = w_rsp_keep;
      end else if (w_buf_count != '0) begin
         w_load_head = 1'b1;
         w_buf_pop   = 1'b1;
         w_buf_push  = w_rsp_keep;
      end else if (w_rsp_keep) begin
         w_load_rsp = 1'b1;
      end else begin
         w_bubble = 1'b1;
      end
   end

   // Outstanding count after this cycle's accept and response
   always_comb begin
      w_out_next = r_outstanding;
      if (w_accept && !imem.imem_rsp_valid)      w_out_next = r_outstanding + CNT_W'(1);
      else if (!w_accept && imem.imem_rsp_valid) w_out_next = r_outstanding - CNT_W'(1);
   end

   // PC, outstanding and drop bookkeeping
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_pc          <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_drop_cnt <= w_out_next;
         end else begin
            if (w_accept)   r_pc       <= r_pc + ADDR_W'(4);
            if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
         end
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_if_id_valid <= 1'b0;
         r_if_id_pc    <= '0;
         r_if_id_instr <= '0;
      end else if (redirect_valid) begin
         r_if_id_valid <= 1'b0;
      end else if (w_load_head) begin
         r_if_id_valid <= 1'b1;
         r_if_id_pc    <= ADDR_W'(w_head_entry.pc);
         r_if_id_instr <= INSTR_W'(w_head_entry.instr);
      end else if (w_load_rsp) begin
         r_if_id_valid <= 1'b1;
         r_if_id_pc    <= w_rsp_tag;
         r_if_id_instr <= imem.imem_rsp_data;
      end else if (w_bubble) begin
         r_if_id_valid <= 1'b0;
      end
   end

   assign if_id_valid = r_if_id_valid;
   assign if_id_pc    = r_if_id_pc;
   assign if_id_instr = r_if_id_instr;
   assign if_id_rs1   = r_if_id_instr[cpu_pkg::RS1_LSB +: 5];
   assign if_id_rs2   = r_if_id_instr[cpu_pkg::RS2_LSB +: 5];

   // Fetched words waiting for IF/ID
   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(cpu_pkg::fetch_entry_t))
   ) u_instr_buf (
      .clk     (clk),
      .arst    (arst),
      .i_push  (w_buf_push),
      .i_pop   (w_buf_pop),
      .i_flush (redirect_valid),
      .i_data  (w_push_entry),
      .o_data  (w_head_entry),
      .o_count (w_buf_count)
   );

   // PC of each accepted, not-yet-answered request on the current path
   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ADDR_W)
   ) u_tag_buf (
      .clk     (clk),
      .arst    (arst),
      .i_push  (w_accept),
      .i_pop   (w_tag_pop),
      .i_flush (redirect_valid),
      .i_data  (r_pc),
      .o_data  (w_rsp_tag),
      .o_count (w_tag_count)
   );

   a_tag_for_rsp: assert property (@(posedge clk) disable iff (arst)
      w_rsp_keep |-> (w_tag_count != '0));

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_bubble_cnt;
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_flush_cnt;

   // Saturating event counters
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_perf_bubble_cnt <= '0;
         r_perf_stall_cnt  <= '0;
         r_perf_flush_cnt  <= '0;
      end else begin
         if (w_bubble && (r_perf_bubble_cnt != '1))      r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
         if (stall_if_id && (r_perf_stall_cnt != '1))    r_perf_stall_cnt  <= r_perf_stall_cnt + 32'd1;
         if (redirect_valid && (r_perf_flush_cnt != '1)) r_perf_flush_cnt  <= r_perf_flush_cnt + 32'd1;
      end
   end

   assign perf_bubble_cnt = r_perf_bubble_cnt;
   assign perf_stall_cnt  = r_perf_stall_cnt;
   assign perf_flush_cnt  = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with an in-order fixed-latency
// instruction memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic        stall_pc = 1'b0;
   logic        stall_if_id = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic [4:0]  if_id_rs1;
   logic [4:0]  if_id_rs2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubble_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

   fetch_stage dut (
      .clk            (clk),
      .arst           (arst),
      .stall_pc       (stall_pc),
      .stall_if_id    (stall_if_id),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_bubble_cnt (perf_bubble_cnt),
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;    // apply reset before this vector
      int          lat;    // memory latency after that reset
      bit          sp;
      bit          sif;
      bit          rd;
      logic [31:0] rpc;
      bit          rdy;
      bit          e_rv;   // expected imem_req_valid
      logic [31:0] e_addr; // expected imem_req_addr
      bit          e_iv;   // expected if_id_valid
      logic [31:0] e_pc;   // expected if_id_pc when valid
   } vec_t;

   vec_t        vecs[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mq_addr[$];
   int          mq_t[$];
   int          cyc = 0;
   int          lat = 1;

   // Memory contents: an address-derived word with varying register fields
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic add(input bit rst, input int l, input bit sp, input bit sif, input bit rd,
                      input logic [31:0] rpc, input bit rdy, input bit e_rv,
                      input logic [31:0] e_addr, input bit e_iv, input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.lat = l; v.sp = sp; v.sif = sif; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   // Called just after a rising edge: advance the memory and drive this cycle's response
   task automatic mem_step(input bit acc, input logic [31:0] a);
      cyc++;
      if (acc) begin
         mq_addr.push_back(a);
         mq_t.push_back(cyc);
      end
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = '0;
      if (mq_addr.size() > 0 && (cyc - mq_t[0] + 1) >= lat) begin
         imem.imem_rsp_valid = 1'b1;
         imem.imem_rsp_data  = mem_word(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_t.pop_front());
      end
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without a clock edge
   task automatic do_reset(input int l, input string tag);
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = '0;
      mq_addr.delete();
      mq_t.delete();
      stall_pc = 1'b0; stall_if_id = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      arst = 1'b1;
      #1;
      chk({tag, " rst req_valid"}, 32'(imem.imem_req_valid), 32'd0);
      chk({tag, " rst req_addr"},  imem.imem_req_addr, 32'h0);
      chk({tag, " rst if_id_valid"}, 32'(if_id_valid), 32'd0);
      chk({tag, " rst if_id_pc"},    if_id_pc, 32'h0);
      chk({tag, " rst if_id_instr"}, if_id_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, " rst perf_bubble"}, perf_bubble_cnt, 32'd0);
      chk({tag, " rst perf_stall"},  perf_stall_cnt, 32'd0);
      chk({tag, " rst perf_flush"},  perf_flush_cnt, 32'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      arst = 1'b0;
      lat  = l;
   endtask

   initial begin
      vec_t        v;
      bit          acc;
      logic [31:0] acc_addr;
      logic [31:0] exp_instr;
      logic [4:0]  exp_rs;
      string       nm;

      imem.imem_req_ready = 1'b1;
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = '0;

      //   rst lat sp sif rd rpc           rdy  rv addr          iv pc
      // Streaming, IF/ID stall, ready low, redirect+rsp under stall, wrap, stall_pc
      add(1, 1, 0, 0, 0, 32'h0,         1,   1, 32'h00,        0, 32'h0);        // c0
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h04,        0, 32'h0);        // c1
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h08,        1, 32'h00);       // c2
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h0C,        1, 32'h04);       // c3
      add(0, 1, 0, 1, 0, 32'h0,         1,   1, 32'h10,        1, 32'h08);       // c4
      add(0, 1, 0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h08);       // c5
      add(0, 1, 0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h08);       // c6
      add(0, 1, 0, 0, 0, 32'h0,         1,   0, 32'h14,        1, 32'h08);       // c7
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h14,        1, 32'h0C);       // c8
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h18,        1, 32'h10);       // c9
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h1C,        1, 32'h14);       // c10
      add(0, 1, 0, 0, 0, 32'h0,         0,   1, 32'h20,        1, 32'h18);       // c11
      add(0, 1, 0, 0, 0, 32'h0,         0,   1, 32'h20,        1, 32'h1C);       // c12
      add(0, 1, 0, 0, 0, 32'h0,         0,   1, 32'h20,        0, 32'h0);        // c13
      add(0, 1, 0, 0, 0, 32'h0,         0,   1, 32'h20,        0, 32'h0);        // c14
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h20,        0, 32'h0);        // c15
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h24,        0, 32'h0);        // c16
      add(0, 1, 0, 1, 1, 32'h200,       1,   0, 32'h28,        1, 32'h20);       // c17
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h200,       0, 32'h0);        // c18
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h204,       0, 32'h0);        // c19
      add(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1,   0, 32'h208,       1, 32'h200);      // c20
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0);        // c21
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h00,        0, 32'h0);        // c22
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h04,        1, 32'hFFFF_FFFC);// c23
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h08,        1, 32'h00);       // c24
      add(0, 1, 1, 0, 0, 32'h0,         1,   0, 32'h0C,        1, 32'h04);       // c25
      add(0, 1, 1, 0, 0, 32'h0,         1,   0, 32'h0C,        1, 32'h08);       // c26
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h0C,        0, 32'h0);        // c27
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h10,        0, 32'h0);        // c28
      add(0, 1, 0, 0, 0, 32'h0,         1,   1, 32'h14,        1, 32'h0C);       // c29
      // Mid-stream reset, then redirect with two requests in flight at latency 3
      add(1, 3, 0, 0, 0, 32'h0,         1,   1, 32'h00,        0, 32'h0);        // d0
      add(0, 3, 0, 0, 0, 32'h0,         1,   1, 32'h04,        0, 32'h0);        // d1
      add(0, 3, 0, 0, 1, 32'h100,       1,   0, 32'h08,        0, 32'h0);        // d2
      add(0, 3, 0, 0, 0, 32'h0,         1,   0, 32'h100,       0, 32'h0);        // d3
      add(0, 3, 0, 0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0);        // d4
      add(0, 3, 0, 0, 0, 32'h0,         1,   1, 32'h104,       0, 32'h0);        // d5
      add(0, 3, 0, 0, 0, 32'h0,         1,   0, 32'h108,       0, 32'h0);        // d6
      add(0, 3, 0, 0, 0, 32'h0,         1,   0, 32'h108,       0, 32'h0);        // d7
      add(0, 3, 0, 0, 0, 32'h0,         1,   1, 32'h108,       1, 32'h100);      // d8
      add(0, 3, 0, 0, 0, 32'h0,         1,   1, 32'h10C,       1, 32'h104);      // d9

      #2;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.rst) do_reset(v.lat, $sformatf("v%0d", i));
         stall_pc            = v.sp;
         stall_if_id         = v.sif;
         redirect_valid      = v.rd;
         redirect_pc         = v.rpc;
         imem.imem_req_ready = v.rdy;
         #1;
         nm = $sformatf("v%0d", i);
         chk({nm, " req_valid"},   32'(imem.imem_req_valid), 32'(v.e_rv));
         chk({nm, " req_addr"},    imem.imem_req_addr, v.e_addr);
         chk({nm, " if_id_valid"}, 32'(if_id_valid), 32'(v.e_iv));
         if (v.e_iv) begin
            exp_instr = mem_word(v.e_pc);
            chk({nm, " if_id_pc"},    if_id_pc, v.e_pc);
            chk({nm, " if_id_instr"}, if_id_instr, exp_instr);
            exp_rs = exp_instr[19:15];
            chk({nm, " if_id_rs1"},   32'(if_id_rs1), 32'(exp_rs));
            exp_rs = exp_instr[24:20];
            chk({nm, " if_id_rs2"},   32'(if_id_rs2), 32'(exp_rs));
         end
         acc      = imem.imem_req_valid && imem.imem_req_ready;
         acc_addr = imem.imem_req_addr;
         @(posedge clk);
         #1;
         mem_step(acc, acc_addr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
